// File: rtl/bioz_iq_accumulator.sv
// BioZ I/Q demodulator-accumulator: weights ADC samples by the synchronized
// quadrant reference and emits per-frame I/Q sums on a valid/ready port.
module bioz_iq_accumulator #(
    parameter int DW     = 12,
    parameter int NPER_W = 8,
    parameter int ACC_W  = 32
) (
    input  logic                    Clk,
    input  logic                    Resetn,
    input  logic                    Enable,
    input  logic [NPER_W-1:0]       NumPeriods,
    input  logic                    IP,
    input  logic                    QP,
    input  logic                    IN,
    input  logic                    QN,
    input  logic signed [DW-1:0]    AdcData,
    input  logic                    AdcValid,
    output logic signed [ACC_W-1:0] IOut,
    output logic signed [ACC_W-1:0] QOut,
    output logic                    OutValid,
    input  logic                    OutReady,
    output logic                    Overflow,
    output logic                    PhaseErr
);

    typedef enum logic [1:0] {IDLE, ARM, ACCUM} state_t;

    state_t                  state;
    logic [3:0]              sync1;
    logic [3:0]              ph;
    logic                    ip_d;
    logic [1:0]              inv_cnt;
    logic [NPER_W-1:0]       pcnt;
    logic [NPER_W-1:0]       nper_r;
    logic [NPER_W-1:0]       nper_eff;
    logic signed [ACC_W-1:0] acc_i;
    logic signed [ACC_W-1:0] acc_q;
    logic signed [ACC_W-1:0] d_i;
    logic signed [ACC_W-1:0] d_q;
    logic signed [ACC_W-1:0] sample;
    logic                    boundary;
    logic                    one_hot;
    logic                    last_period;
    logic                    load;

    // Quadrant references come from the Clk_IF domain; ph is ordered {QN, IN, QP, IP}
    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            sync1 <= '0;
            ph    <= '0;
            ip_d  <= 1'b0;
        end else begin
            sync1 <= {QN, IN, QP, IP};
            ph    <= sync1;
            ip_d  <= ph[0];
        end
    end

    assign boundary    = ph[0] & ~ip_d;
    assign one_hot     = (ph != 4'd0) && ((ph & (ph - 4'd1)) == 4'd0);
    assign sample      = {{(ACC_W-DW){AdcData[DW-1]}}, AdcData};
    assign nper_eff    = (NumPeriods == '0) ? NPER_W'(1) : NumPeriods;
    assign last_period = (pcnt == nper_r - NPER_W'(1));
    assign load        = Enable && (state == ACCUM) && boundary && last_period;

    always_comb begin
        d_i = '0;
        d_q = '0;
        if (AdcValid && one_hot) begin
            case (ph)
                4'b0001: d_i = sample;
                4'b0100: d_i = -sample;
                4'b0010: d_q = sample;
                4'b1000: d_q = -sample;
                default: ;
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            state    <= IDLE;
            pcnt     <= '0;
            nper_r   <= '0;
            acc_i    <= '0;
            acc_q    <= '0;
            IOut     <= '0;
            QOut     <= '0;
            OutValid <= 1'b0;
            Overflow <= 1'b0;
        end else begin
            // Results survive an Enable drop; only the handshake retires them
            if (load) begin
                IOut     <= acc_i;
                QOut     <= acc_q;
                OutValid <= 1'b1;
            end else if (OutReady) begin
                OutValid <= 1'b0;
            end

            if (!Enable)
                Overflow <= 1'b0;
            else if (load && OutValid && !OutReady)
                Overflow <= 1'b1;

            if (!Enable) begin
                state <= IDLE;
                pcnt  <= '0;
                acc_i <= '0;
                acc_q <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        pcnt  <= '0;
                        acc_i <= '0;
                        acc_q <= '0;
                        state <= ARM;
                    end
                    ARM: begin
                        if (boundary) begin
                            state  <= ACCUM;
                            nper_r <= nper_eff;
                            pcnt   <= '0;
                            acc_i  <= d_i;
                            acc_q  <= d_q;
                        end
                    end
                    ACCUM: begin
                        // Frames abut: the boundary sample seeds the next frame
                        if (boundary && last_period) begin
                            acc_i  <= d_i;
                            acc_q  <= d_q;
                            pcnt   <= '0;
                            nper_r <= nper_eff;
                        end else begin
                            acc_i <= acc_i + d_i;
                            acc_q <= acc_q + d_q;
                            if (boundary)
                                pcnt <= pcnt + NPER_W'(1);
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // PhaseErr needs two consecutive non-one-hot cycles, so single glitches pass
    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            inv_cnt  <= '0;
            PhaseErr <= 1'b0;
        end else if (!Enable) begin
            inv_cnt  <= '0;
            PhaseErr <= 1'b0;
        end else if (one_hot) begin
            inv_cnt <= '0;
        end else begin
            if (inv_cnt != 2'd2)
                inv_cnt <= inv_cnt + 2'd1;
            if (inv_cnt != 2'd0)
                PhaseErr <= 1'b1;
        end
    end

endmodule

// File: tb/tb_bioz_iq_accumulator.sv
// Self-checking bench for bioz_iq_accumulator: a frame-level reference model
// tracks expected outputs every cycle, plus directed literal result checks.
module tb_bioz_iq_accumulator;

    logic              Clk = 1'b0;
    logic              Resetn = 1'b0;
    logic              Enable = 1'b0;
    logic [7:0]        NumPeriods = 8'd1;
    logic              IP = 1'b0, QP = 1'b0, IN = 1'b0, QN = 1'b0;
    logic signed [11:0] AdcData = '0;
    logic              AdcValid = 1'b0;
    logic              OutReady = 1'b0;

    logic [31:0] IOut, QOut;
    logic        OutValid, Overflow, PhaseErr;
    logic [15:0] IOut16, QOut16;
    logic        OutValid16, Overflow16, PhaseErr16;

    int n_checks = 0;
    int n_fail   = 0;

    // stimulus generator configuration, quadrant index 0=IP 1=QP 2=IN 3=QN
    int                 qlen = 4;
    int                 pos = 0;
    logic signed [11:0] qval [4] = '{12'sd0, 12'sd0, 12'sd0, 12'sd0};
    bit                 rnd_data = 0, rnd_valid = 0;
    int                 glitch_cnt = 0;
    logic [3:0]         glitch_pat = 4'd0;
    int                 qd1 = -1, qd2 = -1;

    // reference model state
    logic [3:0]  hist [$] = '{4'd0, 4'd0, 4'd0};
    int          m_mode = 0, m_pc = 0, m_nper = 1, m_inv = 0;
    logic [31:0] m_ai = 0, m_aq = 0, m_iout = 0, m_qout = 0;
    bit          m_valid = 0, m_ovf = 0, m_perr = 0;

    bioz_iq_accumulator dut (
        .Clk(Clk), .Resetn(Resetn), .Enable(Enable), .NumPeriods(NumPeriods),
        .IP(IP), .QP(QP), .IN(IN), .QN(QN), .AdcData(AdcData), .AdcValid(AdcValid),
        .IOut(IOut), .QOut(QOut), .OutValid(OutValid), .OutReady(OutReady),
        .Overflow(Overflow), .PhaseErr(PhaseErr)
    );

    bioz_iq_accumulator #(.DW(12), .NPER_W(8), .ACC_W(16)) dut16 (
        .Clk(Clk), .Resetn(Resetn), .Enable(Enable), .NumPeriods(NumPeriods),
        .IP(IP), .QP(QP), .IN(IN), .QN(QN), .AdcData(AdcData), .AdcValid(AdcValid),
        .IOut(IOut16), .QOut(QOut16), .OutValid(OutValid16), .OutReady(OutReady),
        .Overflow(Overflow16), .PhaseErr(PhaseErr16)
    );

    always #5 Clk = ~Clk;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Data for a cycle follows the quadrant driven two cycles earlier, matching the synchronizer delay
    task automatic apply_stimulus();
        int         q;
        logic [3:0] pv;
        q  = pos / qlen;
        pv = 4'd1 << q;
        if (glitch_cnt > 0) begin
            pv = glitch_pat;
            glitch_cnt--;
        end
        {QN, IN, QP, IP} = pv;
        if (rnd_data)
            AdcData = 12'($urandom);
        else
            AdcData = (qd2 >= 0) ? qval[qd2] : 12'sd0;
        AdcValid = rnd_valid ? 1'($urandom_range(0, 1)) : 1'b1;
        qd2 = qd1;
        qd1 = q;
        pos = (pos + 1) % (4 * qlen);
    endtask

    initial forever begin
        @(posedge Clk);
        #1;
        apply_stimulus();
    end

    task automatic model_reset();
        hist = '{4'd0, 4'd0, 4'd0};
        m_mode = 0; m_pc = 0; m_nper = 1; m_inv = 0;
        m_ai = 0; m_aq = 0; m_iout = 0; m_qout = 0;
        m_valid = 0; m_ovf = 0; m_perr = 0;
    endtask

    task automatic model_step();
        logic [3:0]         ph;
        bit                 bnd, oh, load;
        logic signed [31:0] x;
        logic [31:0]        ci, cq, li, lq;
        ph   = hist[1];
        bnd  = ph[0] && !hist[2][0];
        oh   = ($countones(ph) == 1);
        x    = AdcData;
        ci   = 0; cq = 0; li = 0; lq = 0;
        load = 0;
        if (AdcValid && oh) begin
            if (ph[0]) ci = x;
            if (ph[2]) ci = -x;
            if (ph[1]) cq = x;
            if (ph[3]) cq = -x;
        end
        if (!Enable) begin
            m_inv = 0; m_perr = 0;
        end else if (oh) begin
            m_inv = 0;
        end else begin
            m_inv = (m_inv >= 2) ? 2 : m_inv + 1;
            if (m_inv >= 2) m_perr = 1;
        end
        if (!Enable) begin
            m_mode = 0; m_ai = 0; m_aq = 0; m_pc = 0;
        end else if (m_mode == 0) begin
            m_mode = 1; m_ai = 0; m_aq = 0; m_pc = 0;
        end else if (m_mode == 1) begin
            if (bnd) begin
                m_mode = 2; m_pc = 0; m_ai = ci; m_aq = cq;
                m_nper = (NumPeriods == 0) ? 1 : int'(NumPeriods);
            end
        end else begin
            if (bnd && m_pc == m_nper - 1) begin
                load = 1; li = m_ai; lq = m_aq;
                m_ai = ci; m_aq = cq; m_pc = 0;
                m_nper = (NumPeriods == 0) ? 1 : int'(NumPeriods);
            end else begin
                m_ai = m_ai + ci;
                m_aq = m_aq + cq;
                if (bnd) m_pc++;
            end
        end
        if (load) begin
            if (m_valid && !OutReady) m_ovf = 1;
            m_valid = 1; m_iout = li; m_qout = lq;
        end else if (m_valid && OutReady) begin
            m_valid = 0;
        end
        if (!Enable) m_ovf = 0;
        hist.push_front({QN, IN, QP, IP});
        void'(hist.pop_back());
    endtask

    initial forever begin
        @(posedge Clk or negedge Resetn);
        if (!Resetn) model_reset();
        else model_step();
    end

    initial forever begin
        @(negedge Clk);
        check_output("OutValid", 32'(OutValid), 32'(m_valid));
        check_output("IOut", IOut, m_iout);
        check_output("QOut", QOut, m_qout);
        check_output("Overflow", 32'(Overflow), 32'(m_ovf));
        check_output("PhaseErr", 32'(PhaseErr), 32'(m_perr));
        check_output("OutValid16", 32'(OutValid16), 32'(m_valid));
        check_output("IOut16", 32'(IOut16), 32'(m_iout[15:0]));
        check_output("QOut16", 32'(QOut16), 32'(m_qout[15:0]));
        check_output("Overflow16", 32'(Overflow16), 32'(m_ovf));
        check_output("PhaseErr16", 32'(PhaseErr16), 32'(m_perr));
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge Clk);
            #3;
        end
    endtask

    task automatic restart(input int ql, input logic signed [11:0] v0, v1, v2, v3, input logic [7:0] np);
        Enable = 1'b0;
        tick(1);
        qlen = ql; pos = 0;
        qval[0] = v0; qval[1] = v1; qval[2] = v2; qval[3] = v3;
        NumPeriods = np;
        tick(3);
        Enable = 1'b1;
    endtask

    task automatic wait_result(input string name, input bit w16, input logic [31:0] ei, eq, input int budget);
        bit got = 0;
        for (int c = 0; c < budget && !got; c++) begin
            @(negedge Clk);
            if ((w16 ? OutValid16 : OutValid) && OutReady) begin
                got = 1;
                check_output({name, "_I"}, w16 ? 32'(IOut16) : IOut, ei);
                check_output({name, "_Q"}, w16 ? 32'(QOut16) : QOut, eq);
            end
        end
        if (!got) begin
            n_checks++; n_fail++;
            $display("[TB] FAIL %s: got no result expected one within %0d cycles", name, budget);
        end
        @(posedge Clk);
        #3;
    endtask

    task automatic wait_pos(input int p);
        for (int i = 0; i < 200 && pos != p; i++) tick(1);
        if (pos != p) begin
            n_checks++; n_fail++;
            $display("[TB] FAIL wait_pos: got %0d expected %0d", pos, p);
        end
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        OutReady = 1'b1;
        tick(3);
        Resetn = 1'b1;
        tick(4);

        // IP/IN weighting, one period per frame
        restart(4, 12'sd100, 12'sd0, -12'sd100, 12'sd0, 8'd1);
        wait_result("ip_in_n1_a", 0, 32'd800, 32'd0, 60);
        wait_result("ip_in_n1_b", 0, 32'd800, 32'd0, 20);

        // QP/QN weighting over three periods, then NumPeriods=0
        restart(4, 12'sd0, 12'sd50, 12'sd0, -12'sd50, 8'd3);
        wait_result("qp_qn_n3", 0, 32'd0, 32'd1200, 100);
        restart(4, 12'sd0, 12'sd50, 12'sd0, -12'sd50, 8'd0);
        wait_result("qp_qn_n0", 0, 32'd0, 32'd400, 60);

        // overwrite without consumption
        restart(4, 12'sd100, 12'sd0, -12'sd100, 12'sd0, 8'd1);
        OutReady = 1'b0;
        tick(60);
        @(negedge Clk);
        check_output("ovf_set", 32'(Overflow), 32'd1);
        check_output("ovf_valid", 32'(OutValid), 32'd1);
        check_output("ovf_iout", IOut, 32'd800);
        tick(1);
        wait_pos(6);
        OutReady = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        check_output("ready_clears_valid", 32'(OutValid), 32'd0);
        check_output("ovf_sticky", 32'(Overflow), 32'd1);
        tick(1);
        Enable = 1'b0;
        @(negedge Clk);
        tick(1);
        @(negedge Clk);
        check_output("ovf_cleared", 32'(Overflow), 32'd0);
        tick(1);

        // phase errors: 3-cycle IP+QP overlap, then a single zero gap
        restart(4, 12'sd100, 12'sd0, -12'sd100, 12'sd0, 8'd1);
        tick(20);
        check_output("perr_clean", 32'(PhaseErr), 32'd0);
        wait_pos(13);
        glitch_pat = 4'b0011; glitch_cnt = 3;
        tick(6);
        check_output("perr_overlap", 32'(PhaseErr), 32'd1);
        restart(4, 12'sd100, 12'sd0, -12'sd100, 12'sd0, 8'd1);
        check_output("perr_cleared", 32'(PhaseErr), 32'd0);
        tick(20);
        wait_pos(5);
        glitch_pat = 4'b0000; glitch_cnt = 1;
        tick(6);
        check_output("perr_single_gap", 32'(PhaseErr), 32'd0);

        // partial frame discarded on Enable drop
        restart(4, 12'sd100, 12'sd0, -12'sd100, 12'sd0, 8'd1);
        wait_result("pre_abort", 0, 32'd800, 32'd0, 60);
        tick(6);
        Enable = 1'b0;
        tick(2);
        Enable = 1'b1;
        wait_result("post_abort", 0, 32'd800, 32'd0, 60);

        // 16-bit accumulator wraps: 32 x 2047 in IP
        restart(32, 12'sd2047, 12'sd0, 12'sd0, 12'sd0, 8'd1);
        wait_result("wrap16", 1, 32'h0000FFE0, 32'd0, 300);

        // randomized run
        restart($urandom_range(2, 5), 12'sd0, 12'sd0, 12'sd0, 12'sd0, 8'd1);
        rnd_data = 1; rnd_valid = 1;
        for (int c = 0; c < 1500; c++) begin
            tick(1);
            OutReady = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 40) == 0) NumPeriods = 8'($urandom_range(0, 3));
            if ($urandom_range(0, 150) == 0) Enable = 1'b0;
            else if (!Enable && $urandom_range(0, 2) == 0) Enable = 1'b1;
            if (glitch_cnt == 0 && $urandom_range(0, 120) == 0) begin
                glitch_pat = 4'($urandom);
                glitch_cnt = $urandom_range(1, 3);
            end
            if (c == 700) Resetn = 1'b0;
            if (c == 702) Resetn = 1'b1;
        end
        tick(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
